deinterleaver_top: RTL and testbench

- Receive-side counterpart of the transmit interleaver path, for WiMAX QPSK, Ncbps=192, d=16.
- Accepts one soft-decided coded bit per cycle from the demapper, in interleaved (channel) order.
- Undoes the block permutation into an internal 2×Ncbps ping-pong bit store.
- Streams each completed block in original coded order to the FEC decoder over a valid/ready handshake.

---
 rtl/deinterleaver_top.sv | 125 ++++++++++++
 tb/tb_deinterleaver_top.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deinterleaver_top.sv
// rtl/deinterleaver_top.sv - WiMAX QPSK block deinterleaver with ping-pong bit store
// Writes arrive in channel order and are scattered into the bank; reads stream out sequentially.
module deinterleaver_top #(
  parameter int NCBPS = 192,
  parameter int NCPC  = 2,
  parameter int D     = 16
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic [7:0] data_out_index,
  output logic       valid_out,
  input  logic       ready_in
);

  localparam int S  = NCPC / 2;
  localparam int R  = NCBPS / D;
  localparam int AB = $clog2(D);
  localparam int BB = $clog2(R);
  localparam logic [AB-1:0] A_LAST   = AB'(D - 1);
  localparam logic [BB-1:0] B_LAST   = BB'(R - 1);
  localparam logic [7:0]    D_STEP   = 8'(D);
  localparam logic [7:0]    IDX_LAST = 8'(NCBPS - 1);

  generate
    if (S != 1) begin : g_span_check
      $fatal(1, "deinterleaver_top: second-permutation span must be 1");
    end
    if ((NCBPS % D) != 0 || NCBPS > 256) begin : g_size_check
      $fatal(1, "deinterleaver_top: NCBPS must be a multiple of D and at most 256");
    end
  endgenerate

  logic [NCBPS-1:0] bank0;
  logic [NCBPS-1:0] bank1;
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             wr_bank;
  logic             rd_bank;
  logic [AB-1:0]    a;
  logic [BB-1:0]    b;
  logic [7:0]       waddr;
  logic [7:0]       rd_cnt;
  logic             accept;
  logic             last_in;
  logic             load;
  logic             last_out;
  logic             rd_bit;

  assign ready_out = ~full[wr_bank];
  assign accept    = valid_in & ready_out;
  assign last_in   = accept & (a == A_LAST) & (b == B_LAST);
  assign load      = full[rd_bank] & (~valid_out | ready_in);
  assign last_out  = load & (rd_cnt == IDX_LAST);
  assign rd_bit    = rd_bank ? bank1[rd_cnt] : bank0[rd_cnt];

  // Writer only ever sets a non-full bank and reader only clears a full one, so both apply.
  always_comb begin
    full_nxt = full;
    if (last_in)  full_nxt[wr_bank] = 1'b1;
    if (last_out) full_nxt[rd_bank] = 1'b0;
  end

  // Bit store carries no reset; the full flags decide what is meaningful.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (wr_bank) bank1[waddr] <= data_in;
      else         bank0[waddr] <= data_in;
    end
  end

  // Received j = R*a + b lands at original k = a + D*b, built by stepping D per bit.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      a       <= '0;
      b       <= '0;
      waddr   <= '0;
    end else begin
      full <= full_nxt;
      if (accept) begin
        if (last_in) begin
          wr_bank <= ~wr_bank;
          a       <= '0;
          b       <= '0;
          waddr   <= '0;
        end else if (b == B_LAST) begin
          b     <= '0;
          a     <= a + 1'b1;
          waddr <= 8'(a) + 8'd1;
        end else begin
          b     <= b + 1'b1;
          waddr <= waddr + D_STEP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      rd_bank        <= 1'b0;
      rd_cnt         <= '0;
      data_out       <= 1'b0;
      data_out_index <= '0;
      valid_out      <= 1'b0;
    end else if (load) begin
      data_out       <= rd_bit;
      data_out_index <= rd_cnt;
      valid_out      <= 1'b1;
      if (last_out) begin
        rd_bank <= ~rd_bank;
        rd_cnt  <= '0;
      end else begin
        rd_cnt <= rd_cnt + 8'd1;
      end
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_deinterleaver_top.sv
// tb/tb_deinterleaver_top.sv - randomized self-checking bench for deinterleaver_top
// Expected blocks come from the closed-form permutation and a transmit-side interleaver model.
module tb_deinterleaver_top;

  localparam int N = 192;
  localparam int D = 16;

  logic       clk;
  logic       resetN;
  logic       data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic [7:0] data_out_index;
  logic       valid_out;
  logic       ready_in;

  int   n_checks = 0;
  int   n_fail = 0;
  int   rdy_mode = 1;
  logic exp_q[$];
  int   exp_idx = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   in_stalls = 0;
  int   ph_xfer = 0;
  int   ph_first = -1;
  int   ph_last = -1;
  bit   held_v = 0;
  logic h_d;
  logic [7:0] h_i;
  bit   bp_phase = 0;
  bit   seen191 = 0;
  logic prev_ro = 1'b0;

  deinterleaver_top dut (
    .clk            (clk),
    .resetN         (resetN),
    .data_in        (data_in),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .data_out       (data_out),
    .data_out_index (data_out_index),
    .valid_out      (valid_out),
    .ready_in       (ready_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] deint_model(input logic [N-1:0] rx);
    logic [N-1:0] o;
    o = '0;
    for (int j = 0; j < N; j++) o[D*j - (N-1)*((D*j)/N)] = rx[j];
    return o;
  endfunction

  function automatic logic [N-1:0] tx_interleave(input logic [N-1:0] c);
    logic [N-1:0] t;
    t = '0;
    for (int k = 0; k < N; k++) t[(N/D)*(k%D) + k/D] = c[k];
    return t;
  endfunction

  function automatic logic [N-1:0] rand_blk();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Called and returns at posedge+1; expected bits are queued once the final bit is taken.
  task automatic send_block(input logic [N-1:0] rx, input logic [N-1:0] ex,
                            input bit gaps, input int nbits, input bit push);
    int j;
    int waitc;
    j = 0;
    waitc = 0;
    while (j < nbits) begin
      valid_in = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      data_in  = rx[j];
      @(negedge clk);
      if (valid_in && !ready_out) in_stalls++;
      if (valid_in && ready_out) begin
        n_acc++;
        if (push && j == nbits - 1)
          for (int k = 0; k < N; k++) exp_q.push_back(ex[k]);
        j++;
        waitc = 0;
      end else begin
        waitc++;
        if (waitc > 3000) begin
          check("in_timeout", waitc, 0);
          j = nbits;
        end
      end
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    data_in  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 6000) begin
      @(posedge clk);
      t++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetN   = 1'b0;
    valid_in = 1'b0;
    exp_q.delete();
    exp_idx  = 0;
    held_v   = 0;
    @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  initial begin
    ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       ready_in = 1'b0;
        1:       ready_in = 1'b1;
        default: ready_in = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: scoreboard, hold-while-stalled check and phase statistics.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (held_v) begin
        check("hold_valid", int'(valid_out), 1);
        check("hold_data", int'(data_out), int'(h_d));
        check("hold_index", int'(data_out_index), int'(h_i));
      end
      if (resetN && valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", int'(valid_out), 0);
        end else begin
          check("out_data", int'(data_out), int'(exp_q.pop_front()));
          check("out_index", int'(data_out_index), exp_idx);
          exp_idx = (exp_idx + 1) % N;
        end
        ph_xfer++;
        if (ph_first < 0) ph_first = cyc;
        ph_last = cyc;
      end
      if (bp_phase && !seen191 && valid_out && data_out_index == 8'd191) begin
        seen191 = 1;
        check("bp_ready_return", int'(ready_out), 1);
        check("bp_ready_before", int'(prev_ro), 0);
      end
      prev_ro = ready_out;
      held_v  = resetN && valid_out && !ready_in;
      h_d     = data_out;
      h_i     = data_out_index;
    end
  end

  initial begin
    logic [N-1:0] rx;
    logic [N-1:0] ex;
    logic [N-1:0] c;
    int probe_j [3];
    int probe_k [3];
    probe_j = '{12, 1, 191};
    probe_k = '{1, 16, 191};

    resetN   = 1'b0;
    valid_in = 1'b0;
    data_in  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetN = 1'b1;
    @(negedge clk);
    check("rst_ready_out", int'(ready_out), 1);
    check("rst_valid_out", int'(valid_out), 0);
    check("rst_data_out", int'(data_out), 0);
    check("rst_index", int'(data_out_index), 0);
    @(posedge clk);
    #1;

    // Single-one probes with hand-computed target positions.
    for (int p = 0; p < 3; p++) begin
      rx = '0;
      rx[probe_j[p]] = 1'b1;
      ex = '0;
      ex[probe_k[p]] = 1'b1;
      send_block(rx, ex, 1'b0, N, 1'b1);
    end
    wait_drain();

    // Eight back-to-back round trips through the transmit interleaver model.
    in_stalls = 0;
    ph_xfer   = 0;
    ph_first  = -1;
    for (int blk = 0; blk < 8; blk++) begin
      c = rand_blk();
      send_block(tx_interleave(c), c, 1'b0, N, 1'b1);
    end
    wait_drain();
    check("rt_in_stalls", in_stalls, 0);
    check("rt_xfers", ph_xfer, 8*N);
    check("rt_no_bubble", ph_last - ph_first + 1, 8*N);

    // Backpressure: both banks fill, then drain releases bank0 first.
    do_reset();
    rdy_mode = 0;
    @(posedge clk);
    #1;
    n_acc     = 0;
    in_stalls = 0;
    for (int blk = 0; blk < 2; blk++) begin
      rx = rand_blk();
      send_block(rx, deint_model(rx), 1'b0, N, 1'b1);
    end
    check("bp_accepts", n_acc, 2*N);
    check("bp_in_stalls", in_stalls, 0);
    valid_in = 1'b1;
    data_in  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_full_ready", int'(ready_out), 0);
      @(posedge clk);
      #1;
    end
    bp_phase = 1;
    seen191  = 0;
    rdy_mode = 1;
    rx = rand_blk();
    send_block(rx, deint_model(rx), 1'b0, N, 1'b1);
    wait_drain();
    check("bp_seen191", int'(seen191), 1);
    bp_phase = 0;

    // Random output stalls and random input gaps on identical blocks.
    rdy_mode = 2;
    for (int blk = 0; blk < 3; blk++) begin
      rx = rand_blk();
      send_block(rx, deint_model(rx), 1'b0, N, 1'b1);
      send_block(rx, deint_model(rx), 1'b1, N, 1'b1);
    end
    wait_drain();

    // Reset while a block is held at the output and another is partly written.
    rdy_mode = 0;
    @(posedge clk);
    #1;
    rx = rand_blk();
    send_block(rx, deint_model(rx), 1'b0, N, 1'b1);
    rx = rand_blk();
    send_block(rx, deint_model(rx), 1'b0, 100, 1'b0);
    do_reset();
    @(negedge clk);
    check("mid_rst_valid", int'(valid_out), 0);
    check("mid_rst_ready", int'(ready_out), 1);
    check("mid_rst_index", int'(data_out_index), 0);
    @(posedge clk);
    #1;
    rdy_mode = 1;
    c = rand_blk();
    send_block(tx_interleave(c), c, 1'b0, N, 1'b1);
    wait_drain();
    repeat (30) @(posedge clk);
    #1;
    @(negedge clk);
    check("final_idle", int'(valid_out), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
